// File: rtl/dw5_cfu_pkg.sv
// Shared constants and types for the depthwise-5x5 CFU sequencer.
package dw5_cfu_pkg;

  localparam int BYTE_SIZE  = 8;
  localparam int INT32_SIZE = 32;
  localparam int NUM_TAPS   = 25;
  localparam int LANES      = 4;

  // Custom-instruction command codes
  localparam logic [6:0] CMD_CLEAR      = 7'd0;
  localparam logic [6:0] CMD_LOAD_FILT  = 7'd1;
  localparam logic [6:0] CMD_LOAD_ACT   = 7'd2;
  localparam logic [6:0] CMD_SET_OFFSET = 7'd3;
  localparam logic [6:0] CMD_START      = 7'd4;
  localparam logic [6:0] CMD_READ_ACC   = 7'd5;

  // Result codes returned through ret
  localparam logic [31:0] RET_OK        = 32'h0000_0000;
  localparam logic [31:0] RET_BAD_INDEX = 32'h0000_0001;
  localparam logic [31:0] RET_ERROR     = 32'hFFFF_FFFF;
  localparam logic [31:0] RET_DONE      = 32'(NUM_TAPS);

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Extract int8 lane c from a packed 32-bit word
  function automatic logic [7:0] lane_byte(input logic [31:0] word, input int c);
    return word[8*c +: 8];
  endfunction

endpackage

// File: rtl/dw5_mac4.sv
// Four-lane combinational multiplier: (sext(act) + offset) * sext(filt),
// each product sign-extended to 32 bits for the accumulators.
module dw5_mac4
  import dw5_cfu_pkg::*;
(
  input  logic [31:0]          act_word,
  input  logic [31:0]          filt_word,
  input  logic [8:0]           offset,
  output logic [LANES*32-1:0]  prod
);

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic        [7:0]  act_b;
      logic        [7:0]  filt_b;
      logic signed [9:0]  sum_s;
      logic signed [7:0]  filt_s;
      logic signed [17:0] prod_s;

      assign act_b  = lane_byte(act_word, gi);
      assign filt_b = lane_byte(filt_word, gi);

      // 10 bits hold the full range of int8 + signed 9-bit offset
      assign sum_s  = $signed({{2{act_b[7]}}, act_b}) + $signed({offset[8], offset});
      assign filt_s = $signed(filt_b);
      assign prod_s = sum_s * filt_s;

      assign prod[32*gi +: 32] = {{14{prod_s[17]}}, prod_s};
    end
  endgenerate

endmodule

// File: rtl/dw5_cfu_sched.sv
// Command sequencer for the depthwise-5x5 CFU: decodes custom instructions,
// fills the tap buffers and steps the 4-lane MAC through all 25 taps.
module dw5_cfu_sched #(
  parameter int BYTE_SIZE  = 8,
  parameter int INT32_SIZE = 32,
  parameter int NUM_TAPS   = 25,
  parameter int LANES      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [6:0]            cmd,
  input  logic [INT32_SIZE-1:0] inp0,
  input  logic [INT32_SIZE-1:0] inp1,
  output logic [INT32_SIZE-1:0] ret,
  output logic                  output_buffer_valid
);

  import dw5_cfu_pkg::*;

  // Tap buffers: one write port each, read by the running tap index
  logic [31:0] filt_mem [NUM_TAPS];
  logic [31:0] act_mem  [NUM_TAPS];

  state_t      state_reg;
  logic [4:0]  tap_reg;
  logic [8:0]  offset_reg;
  logic [31:0] acc_reg [LANES];
  logic [31:0] ret_reg;
  logic        valid_reg;

  logic        cmd_fire;
  logic [4:0]  tap_idx;
  logic        idx_ok;
  logic [LANES*32-1:0] prod;

  // Upper operand bits carry no meaning for any command
  logic unused_inp0;
  assign unused_inp0 = ^inp0[31:5];

  // A command is accepted only while idle and the result port is valid
  assign cmd_fire = en && valid_reg && (state_reg == IDLE);
  assign tap_idx  = inp0[4:0];
  assign idx_ok   = (tap_idx < 5'(NUM_TAPS));

  dw5_mac4 u_mac4 (
    .act_word  (act_mem[tap_reg]),
    .filt_word (filt_mem[tap_reg]),
    .offset    (offset_reg),
    .prod      (prod)
  );

  // Buffer writes; contents survive reset and START by design
  always_ff @(posedge clk) begin
    if (!reset && cmd_fire && idx_ok) begin
      if (cmd == CMD_LOAD_FILT) filt_mem[tap_idx] <= inp1;
      if (cmd == CMD_LOAD_ACT)  act_mem[tap_idx]  <= inp1;
    end
  end

  // Command decode, tap sequencing and accumulation
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      tap_reg    <= 5'd0;
      offset_reg <= 9'd0;
      ret_reg    <= RET_OK;
      valid_reg  <= 1'b1;
      for (int c = 0; c < LANES; c++) acc_reg[c] <= 32'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cmd_fire) begin
            case (cmd)
              CMD_CLEAR: begin
                for (int c = 0; c < LANES; c++) acc_reg[c] <= 32'd0;
                ret_reg <= RET_OK;
              end
              CMD_LOAD_FILT, CMD_LOAD_ACT: begin
                ret_reg <= idx_ok ? RET_OK : RET_BAD_INDEX;
              end
              CMD_SET_OFFSET: begin
                offset_reg <= inp1[8:0];
                ret_reg    <= RET_OK;
              end
              CMD_START: begin
                // ret deliberately keeps its pre-START value while busy
                state_reg <= RUN;
                tap_reg   <= 5'd0;
                valid_reg <= 1'b0;
              end
              CMD_READ_ACC: begin
                ret_reg <= acc_reg[inp0[1:0]];
              end
              default: begin
                ret_reg <= RET_ERROR;
              end
            endcase
          end
        end
        RUN: begin
          for (int c = 0; c < LANES; c++) acc_reg[c] <= acc_reg[c] + prod[32*c +: 32];
          if (tap_reg == 5'(NUM_TAPS - 1)) begin
            state_reg <= DONE;
            tap_reg   <= 5'd0;
          end else begin
            tap_reg <= tap_reg + 5'd1;
          end
        end
        DONE: begin
          ret_reg   <= RET_DONE;
          valid_reg <= 1'b1;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          valid_reg <= 1'b1;
        end
      endcase
    end
  end

  assign ret                 = ret_reg;
  assign output_buffer_valid = valid_reg;

endmodule
